// File: rtl/lut_neuron_pipe.sv
// Pipelined truth-table neuron: run-time writable LUT, self-clearing after reset/clr,
// valid/ready on both sides. Optional table readback port under LUT_NEURON_PIPE_READBACK_EN.
module lut_neuron_pipe #(
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  parameter int ADDR_W   = FAN_IN * IN_BITS,
  parameter int DEPTH    = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_wdata,
  input  logic                clr,
  output logic                busy,
`ifdef LUT_NEURON_PIPE_READBACK_EN
  input  logic                cfg_re,
  output logic                cfg_rvalid,
  output logic [OUT_BITS-1:0] cfg_rdata,
`endif
  output logic                dbg_state
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic [OUT_BITS-1:0] mem [0:DEPTH-1];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [OUT_BITS-1:0] mem_wdata;
  logic                va, vb, b_free;
  logic [ADDR_W-1:0]   addr_a;

  // Handshake: a word moves across a port on any rising edge where valid & ready are both
  // high; a producer keeps valid and data stable until that edge, ready may depend on valid.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (clr) begin
      state_next = S_CLEAR;
      cnt_next   = '0;
    end else if (state == S_CLEAR) begin
      cnt_next = cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(DEPTH - 1)) state_next = S_RUN;
    end
  end

  always_comb begin
    busy      = (state == S_CLEAR);
    dbg_state = (state == S_RUN);
    in_ready  = (state == S_RUN) && !(va && vb && !out_ready);
    mem_we    = 1'b0;
    mem_waddr = cfg_addr;
    mem_wdata = cfg_wdata;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = '0;
    end else if (cfg_we && !clr) begin
      mem_we = 1'b1;
    end
  end

  // Table has no reset; contents are defined once the CLEAR sweep has finished.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign b_free    = !vb || out_ready;
  assign out_valid = vb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va     <= 1'b0;
      addr_a <= '0;
    end else if (clr) begin
      va <= 1'b0;
    end else if (in_valid && in_ready) begin
      va     <= 1'b1;
      addr_a <= in_data;
    end else if (!(va && !b_free)) begin
      va <= 1'b0;
    end
  end

  // Reading here and writing in the table block on the same edge yields the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb       <= 1'b0;
      out_data <= '0;
    end else if (clr) begin
      vb <= 1'b0;
    end else if (va && b_free) begin
      vb       <= 1'b1;
      out_data <= mem[addr_a];
    end else if (out_ready) begin
      vb <= 1'b0;
    end
  end

`ifdef LUT_NEURON_PIPE_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= cfg_re && (state == S_RUN) && !clr;
      if (cfg_re && (state == S_RUN) && !clr) cfg_rdata <= mem[cfg_addr];
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Directed bench for lut_neuron_pipe: clear timing, streaming lookups, back-pressure,
// read-before-write, clr flush, async reset, and readback when LUT_NEURON_PIPE_READBACK_EN is set.
module tb_lut_neuron_pipe;
  localparam int ADDR_W   = 8;
  localparam int OUT_BITS = 2;

  logic                clk, rst_n;
  logic                in_valid, in_ready;
  logic [ADDR_W-1:0]   in_data;
  logic                out_valid, out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [OUT_BITS-1:0] cfg_wdata;
  logic                clr, busy, dbg_state;
`ifdef LUT_NEURON_PIPE_READBACK_EN
  logic                cfg_re, cfg_rvalid;
  logic [OUT_BITS-1:0] cfg_rdata;
`endif

  lut_neuron_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clr(clr), .busy(busy),
`ifdef LUT_NEURON_PIPE_READBACK_EN
    .cfg_re(cfg_re), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int inflight = 0;
  logic [OUT_BITS-1:0] tbl [256];
  logic [OUT_BITS-1:0] exp_q [$];
  int                  lat_q [$];
  logic [ADDR_W-1:0]   addr_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag, input int exp_n);
    int n = 0;
    int rdy_bad = 0;
    while (busy && n < 2000) begin
      if (in_ready) rdy_bad++;
      step();
      n++;
    end
    check_eq({tag, "_busy_cycles"}, n, exp_n);
    check_eq({tag, "_rdy_in_clear"}, rdy_bad, 0);
    check_eq({tag, "_busy_low"}, busy, 0);
    check_eq({tag, "_in_ready_up"}, in_ready, 1);
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [OUT_BITS-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  // Drains addr_q through the DUT; scoreboard expects tbl[] in order.
  task automatic run_stream(input int rdy_pct, input bit chk_lat);
    int budget = 0;
    logic stall_prev = 1'b0;
    logic [OUT_BITS-1:0] held = '0;
    int lt;
    while ((addr_q.size() > 0 || exp_q.size() > 0) && budget < 4000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (addr_q.size() > 0);
      in_data   = in_valid ? addr_q[0] : '0;
      #1;
      if (stall_prev) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, held);
      end
      check_eq("in_ready", in_ready, !(inflight == 2 && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("extra_output", 1, 0);
        else begin
          check_eq("out_data", out_data, exp_q.pop_front());
          lt = lat_q.pop_front();
          if (chk_lat) check_eq("latency", cyc - lt, 2);
        end
        inflight--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(tbl[in_data]);
        lat_q.push_back(cyc);
        void'(addr_q.pop_front());
        inflight++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 4000) check_eq("stream_timeout", budget, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    lat_q.delete();
    inflight = 0;
    for (int i = 0; i < 256; i++) tbl[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; clr = 1'b0;
`ifdef LUT_NEURON_PIPE_READBACK_EN
    cfg_re = 1'b0;
`endif
    flush_model();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 1);
`ifdef LUT_NEURON_PIPE_READBACK_EN
    check_eq("rst_rvalid", cfg_rvalid, 0);
    check_eq("rst_rdata", cfg_rdata, 0);
`endif
    rst_n = 1'b1;
    wait_clear("init", 256);

    // cleared table: everything reads 00
    addr_q = '{8'h3E, 8'hA5, 8'h00, 8'hFF};
    run_stream(100, 1'b1);

    // three entries set, full sweep at full throughput
    cfg_write(8'h3E, 2'b01);
    cfg_write(8'h3B, 2'b01);
    cfg_write(8'h3F, 2'b01);
    for (int i = 0; i < 256; i++) addr_q.push_back(ADDR_W'(i));
    run_stream(100, 1'b1);

    // permuted sweep with random back-pressure
    for (int i = 0; i < 256; i++) addr_q.push_back(ADDR_W'(i * 37));
    run_stream(50, 1'b0);

    // write and stage-B read of 0x10 on the same edge
    in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 8'h10; cfg_wdata = 2'b11;
    step();
    cfg_we = 1'b0;
    tbl[8'h10] = 2'b11;
    check_eq("rbw_valid", out_valid, 1);
    check_eq("rbw_old_data", out_data, 2'b00);
    step();
    addr_q = '{8'h10};
    run_stream(100, 1'b1);

`ifdef LUT_NEURON_PIPE_READBACK_EN
    cfg_write(8'hA5, 2'b10);
    cfg_re = 1'b1; cfg_addr = 8'hA5;
    step();
    cfg_re = 1'b0;
    check_eq("rb_rvalid", cfg_rvalid, 1);
    check_eq("rb_rdata", cfg_rdata, 2'b10);
    step();
    check_eq("rb_rvalid_once", cfg_rvalid, 0);
`endif

    // clr with two words in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3E;
    step();
    in_data = 8'h3F;
    step();
    in_valid = 1'b0;
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_out_valid", out_valid, 1);
    check_eq("full_out_data", out_data, 2'b01);
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b1;
    check_eq("clr_out_valid", out_valid, 0);
    check_eq("clr_busy", busy, 1);
`ifdef LUT_NEURON_PIPE_READBACK_EN
    cfg_re = 1'b1; cfg_addr = 8'hA5;
    step();
    cfg_re = 1'b0;
    check_eq("rb_in_clear", cfg_rvalid, 0);
    wait_clear("clr", 255);
`else
    wait_clear("clr", 256);
`endif
    flush_model();
    addr_q = '{8'h3E, 8'h3B, 8'h10};
    run_stream(100, 1'b1);

    // asynchronous reset mid-operation
    cfg_write(8'h10, 2'b11);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
    step();
    step();
    in_valid = 1'b0;
    check_eq("pre_rst_valid", out_valid, 1);
    check_eq("pre_rst_data", out_data, 2'b11);
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_busy", busy, 1);
    check_eq("arst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    wait_clear("rerst", 256);
    flush_model();
    addr_q = '{8'h10};
    run_stream(100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
